rx_unit: RTL

Receive unit of the MiniUart and the downstream counterpart of the transmit unit. It takes the serial line (8N1, LSB first, idle high) and oversamples it with a tick at OVS times the baud rate. It validates the start bit at mid-bit and samples each data bit and the stop bit at mid-bit. It then presents the received byte in parallel with receive status, framing-error and overrun flags to the UART register interface.

---
 rtl/rx_unit.sv | 123 ++++++++++++
 1 files changed

// File: rtl/rx_unit.sv
// 8N1 UART receiver: oversamples rxd with en_rx ticks, checks the start bit at
// mid-bit, samples data/stop at mid-bit and flags framing error and overrun.
module rx_unit #(
  parameter int OVS = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  input  logic       en_rx,
  input  logic       rd,
  output logic [7:0] d_out,
  output logic       rs,
  output logic       fe,
  output logic       oe
);
  localparam int CW = $clog2(OVS);
  localparam logic [CW-1:0] HALF = CW'(OVS/2 - 1);
  localparam logic [CW-1:0] FULL = CW'(OVS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, rxd_s_q, prev_q;
  logic [CW-1:0]   tick_q, tick_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      dout_q, dout_d;
  logic            rs_q, rs_d, fe_q, fe_d, oe_q, oe_d;
  logic            fall, sample, done;

  assign fall   = prev_q & ~rxd_s_q;
  assign sample = en_rx && (tick_q == FULL);
  assign done   = (state_q == STOP) && sample;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sync1_q <= 1'b1;
      rxd_s_q <= 1'b1;
      prev_q  <= 1'b1;
      tick_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      rs_q    <= 1'b0;
      fe_q    <= 1'b0;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= rxd;
      rxd_s_q <= sync1_q;
      prev_q  <= rxd_s_q;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      rs_q    <= rs_d;
      fe_q    <= fe_d;
      oe_q    <= oe_d;
    end
  end

  // Edge detection in IDLE runs every clk so a start edge is never missed
  // between oversample ticks; all counting waits for en_rx.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (fall) state_d = START;
      START:   if (en_rx && tick_q == HALF) state_d = rxd_s_q ? IDLE : DATA;
      DATA:    if (sample && bit_q == 3'd7) state_d = STOP;
      STOP:    if (sample) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tick_d  = tick_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: if (fall) tick_d = '0;
      START: if (en_rx) begin
        if (tick_q == HALF) begin
          tick_d = '0;
          bit_d  = '0;
        end else begin
          tick_d = tick_q + 1'b1;
        end
      end
      DATA, STOP: if (en_rx) begin
        tick_d = sample ? '0 : tick_q + 1'b1;
        if (sample && state_q == DATA) begin
          shift_d = {rxd_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
        end
      end
      default: tick_d = '0;
    endcase
  end

  // A completing frame takes priority over a coincident read.
  always_comb begin
    dout_d = dout_q;
    rs_d   = rs_q;
    fe_d   = fe_q;
    oe_d   = oe_q;
    if (done) begin
      dout_d = shift_q;
      rs_d   = 1'b1;
      fe_d   = ~rxd_s_q;
      oe_d   = rs_q & ~rd;
    end else if (rd && rs_q) begin
      rs_d = 1'b0;
      fe_d = 1'b0;
      oe_d = 1'b0;
    end
  end

  assign d_out = dout_q;
  assign rs    = rs_q;
  assign fe    = fe_q;
  assign oe    = oe_q;
endmodule
